// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, 4-state hold FSM with an
// N-bit stable counter, registered level plus one-cycle rise/fall ticks and a combined tick flag.
module debounce_multi #(
    parameter int CH          = 4,
    parameter int N           = 21,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall,
    output logic          db_any
);

    localparam logic [N-1:0] M        = '1;
    localparam logic [N-1:0] CNT_LAST = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam state_t INIT_STATE = INIT_LEVEL ? ONE : ZERO;

    logic [CH-1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0] sw_s;
    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [N-1:0]  cnt_q [CH];
    logic [N-1:0]  cnt_d [CH];
    logic [CH-1:0] level_d;
    logic [CH-1:0] rise_d;
    logic [CH-1:0] fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= {CH{INIT_LEVEL}};
        end else begin
            sync_q[0] <= sw;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    // Entry and abort ignore ce; only the countdown is gated. A reversal during
    // WAITx drops straight back to the stable state, so the next attempt restarts from M.
    always_comb begin
        level_d = '0;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ZERO: begin
                    if (sw_s[i]) begin
                        state_d[i] = WAIT1;
                        cnt_d[i]   = M;
                    end
                end
                WAIT1: begin
                    if (!sw_s[i]) begin
                        state_d[i] = ZERO;
                    end else if (ce) begin
                        if (cnt_q[i] <= CNT_LAST) begin
                            cnt_d[i]   = '0;
                            state_d[i] = ONE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_LAST;
                        end
                    end
                end
                ONE: begin
                    if (!sw_s[i]) begin
                        state_d[i] = WAIT0;
                        cnt_d[i]   = M;
                    end
                end
                WAIT0: begin
                    if (sw_s[i]) begin
                        state_d[i] = ONE;
                    end else if (ce) begin
                        if (cnt_q[i] <= CNT_LAST) begin
                            cnt_d[i]   = '0;
                            state_d[i] = ZERO;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_LAST;
                        end
                    end
                end
                default: begin
                    state_d[i] = INIT_STATE;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
            rise_d[i]  = (state_q[i] == WAIT1) && (state_d[i] == ONE);
            fall_d[i]  = (state_q[i] == WAIT0) && (state_d[i] == ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= INIT_STATE;
                cnt_q[i]   <= '0;
            end
            db_level <= {CH{INIT_LEVEL}};
            db_rise  <= '0;
            db_fall  <= '0;
            db_any   <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            db_level <= level_d;
            db_rise  <= rise_d;
            db_fall  <= fall_d;
            db_any   <= |(rise_d | fall_d);
        end
    end

endmodule
